// File: rtl/register_dump.sv
`default_nettype none
// ============================================================================
// Module   : register_dump
// Purpose  : Walks a register-file read port over a configurable index range
//            and streams each register value out over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module register_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rs1,
    input  logic [31:0] regData,
    output logic [31:0] outData,
    output logic [4:0]  outIndex,
    output logic        outValid,
    input  logic        outReady,
    output logic        busy,
    output logic        done,
    output logic [5:0]  wordCount
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_issue  = 3'd1;
    localparam logic [2:0] c_fetch  = 3'd2;
    localparam logic [2:0] c_send   = 3'd3;
    localparam logic [2:0] c_finish = 3'd4;

    localparam logic [4:0] c_first     = 5'(FIRST_REG);
    localparam logic [4:0] c_last      = 5'(LAST_REG);
    localparam logic [5:0] c_max_count = 6'd32;

    logic [2:0]  r_state;
    logic [4:0]  r_rs1;
    logic [4:0]  r_index;
    logic [31:0] r_data;
    logic        r_valid;
    logic [5:0]  r_count;

    logic w_accept;
    logic w_advance;

    // r_valid is only ever high while in SEND, so the handshake alone marks an accept.
    assign w_accept  = r_valid && outReady;
    assign w_advance = (r_state == c_send) && (w_accept || !r_valid);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_rs1   <= 5'd0;
            r_index <= 5'd0;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 6'd0;
        end else begin
            if (w_accept && (r_count != c_max_count)) begin
                r_count <= r_count + 6'd1;
            end

            case (r_state)
                c_idle: begin
                    if (start && !abort) begin
                        r_rs1   <= c_first;
                        r_count <= 6'd0;
                        r_state <= c_issue;
                    end
                end
                c_issue: begin
                    r_state <= abort ? c_finish : c_fetch;
                end
                c_fetch: begin
                    if (abort) begin
                        r_state <= c_finish;
                    end else begin
                        r_data  <= regData;
                        r_index <= r_rs1;
                        r_valid <= !(SKIP_ZERO && (regData == 32'd0));
                        r_state <= c_send;
                    end
                end
                c_send: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_state <= c_finish;
                    end else if (w_advance) begin
                        r_valid <= 1'b0;
                        if (r_rs1 == c_last) begin
                            r_state <= c_finish;
                        end else begin
                            r_rs1   <= r_rs1 + 5'd1;
                            r_state <= c_issue;
                        end
                    end
                end
                c_finish: begin
                    r_valid <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign rs1       = r_rs1;
    assign outData   = r_data;
    assign outIndex  = r_index;
    assign outValid  = r_valid;
    assign wordCount = r_count;
    assign busy      = (r_state != c_idle);
    assign done      = (r_state == c_finish);

endmodule
`default_nettype wire

// File: tb/tb_register_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_dump
// Purpose  : Directed self-checking bench for register_dump (three parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_dump;

    logic clock;
    logic reset;

    logic        startA, abortA, readyA, validA, busyA, doneA;
    logic [4:0]  rs1A, idxA;
    logic [31:0] rdA, dataA;
    logic [5:0]  wcA;

    logic        startB, abortB, readyB, validB, busyB, doneB;
    logic [4:0]  rs1B, idxB;
    logic [31:0] rdB, dataB;
    logic [5:0]  wcB;

    logic        startC, abortC, readyC, validC, busyC, doneC;
    logic [4:0]  rs1C, idxC;
    logic [31:0] rdC, dataC;
    logic [5:0]  wcC;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  qiA[$], qiB[$], qiC[$];
    logic [31:0] qdA[$], qdB[$], qdC[$];
    int doneCntA = 0, doneCntB = 0, doneCntC = 0;
    logic [4:0] maxRs1C = 5'd0;

    register_dump dutA (
        .clock(clock), .reset(reset), .start(startA), .abort(abortA),
        .rs1(rs1A), .regData(rdA), .outData(dataA), .outIndex(idxA),
        .outValid(validA), .outReady(readyA), .busy(busyA), .done(doneA),
        .wordCount(wcA)
    );

    register_dump #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b1)) dutB (
        .clock(clock), .reset(reset), .start(startB), .abort(abortB),
        .rs1(rs1B), .regData(rdB), .outData(dataB), .outIndex(idxB),
        .outValid(validB), .outReady(readyB), .busy(busyB), .done(doneB),
        .wordCount(wcB)
    );

    register_dump #(.FIRST_REG(4), .LAST_REG(6), .SKIP_ZERO(1'b0)) dutC (
        .clock(clock), .reset(reset), .start(startC), .abort(abortC),
        .rs1(rs1C), .regData(rdC), .outData(dataC), .outIndex(idxC),
        .outValid(validC), .outReady(readyC), .busy(busyC), .done(doneC),
        .wordCount(wcC)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file models with one-edge read latency.
    always @(posedge clock) begin
        rdA <= {27'd0, rs1A};
        rdB <= (rs1B == 5'd2) ? 32'd7 : ((rs1B == 5'd29) ? 32'd252 : 32'd0);
        rdC <= {27'd0, rs1C} + 32'd100;
    end

    always @(posedge clock) begin
        if (validA && readyA) begin qiA.push_back(idxA); qdA.push_back(dataA); end
        if (validB && readyB) begin qiB.push_back(idxB); qdB.push_back(dataB); end
        if (validC && readyC) begin qiC.push_back(idxC); qdC.push_back(dataC); end
        if (doneA) doneCntA = doneCntA + 1;
        if (doneB) doneCntB = doneCntB + 1;
        if (doneC) doneCntC = doneCntC + 1;
        if (rs1C > maxRs1C) maxRs1C = rs1C;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input int w);
        case (w)
            0:       return doneA;
            1:       return doneB;
            default: return doneC;
        endcase
    endfunction

    // Called #1 after an edge; returns the number of edges from the start edge to done.
    task automatic start_and_wait(input int w, output int cyc);
        case (w)
            0:       startA = 1'b1;
            1:       startB = 1'b1;
            default: startC = 1'b1;
        endcase
        @(posedge clock); #1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        cyc = 1;
        while (!sel_done(w) && cyc < 300) begin
            @(posedge clock); #1;
            cyc++;
        end
        check($sformatf("done_seen_%0d", w), 32'(sel_done(w)), 32'd1);
    endtask

    task automatic check_words_A(input string tag);
        check({tag, "_count"}, 32'(qiA.size()), 32'd32);
        for (int i = 0; i < qiA.size() && i < 32; i++) begin
            check($sformatf("%s_idx%0d", tag, i), 32'(qiA[i]), 32'(i));
            check($sformatf("%s_dat%0d", tag, i), qdA[i], 32'(i));
        end
    endtask

    initial begin
        int cyc;
        int n;
        logic stable;
        int dc;

        reset = 1'b1;
        startA = 1'b0; abortA = 1'b0; readyA = 1'b1;
        startB = 1'b0; abortB = 1'b0; readyB = 1'b1;
        startC = 1'b0; abortC = 1'b0; readyC = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_rs1",      32'(rs1A),   32'd0);
        check("rst_outData",  dataA,       32'd0);
        check("rst_outIndex", 32'(idxA),   32'd0);
        check("rst_wordCount",32'(wcA),    32'd0);
        check("rst_outValid", 32'(validA), 32'd0);
        check("rst_busy",     32'(busyA),  32'd0);
        check("rst_done",     32'(doneA),  32'd0);
        check("rst_busyB",    32'(busyB),  32'd0);

        // Release reset and request a dump in the same cycle.
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        start_and_wait(0, cyc);
        check("full_done_cycle", 32'(cyc), 32'd97);
        check("full_wordCount",  32'(wcA), 32'd32);
        check("full_outValid_finish", 32'(validA), 32'd0);
        check_words_A("full");
        @(posedge clock); #1;
        check("full_done_one_cycle", 32'(doneA), 32'd0);
        check("full_idle_busy",      32'(busyA), 32'd0);
        check("full_wc_hold",        32'(wcA),   32'd32);

        // Start together with abort in IDLE is ignored.
        startA = 1'b1; abortA = 1'b1;
        @(posedge clock); #1;
        startA = 1'b0; abortA = 1'b0;
        check("start_abort_busy", 32'(busyA), 32'd0);
        check("start_abort_wc",   32'(wcA),   32'd32);

        // Back-pressure while index 5 is presented.
        qiA.delete(); qdA.delete();
        startA = 1'b1;
        @(posedge clock); #1;
        startA = 1'b0;
        n = 0;
        while (!(rs1A == 5'd5 && !validA) && n < 200) begin @(posedge clock); #1; n++; end
        readyA = 1'b0;
        n = 0;
        while (!validA && n < 10) begin @(posedge clock); #1; n++; end
        check("stall_idx", 32'(idxA), 32'd5);
        check("stall_dat", dataA,     32'd5);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (!(validA === 1'b1 && idxA === 5'd5 && dataA === 32'd5)) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_wc",     32'(wcA),    32'd5);
        readyA = 1'b1;
        n = 0;
        while (!(validA && idxA == 5'd6) && n < 20) begin @(posedge clock); #1; n++; end
        check("stall_next_latency", 32'(n), 32'd3);
        n = 0;
        while (!doneA && n < 300) begin @(posedge clock); #1; n++; end
        check("stall_done", 32'(doneA), 32'd1);
        check_words_A("stall");
        @(posedge clock); #1;

        // Abort while index 10 is held off by the consumer.
        qiA.delete(); qdA.delete();
        startA = 1'b1;
        @(posedge clock); #1;
        startA = 1'b0;
        n = 0;
        while (!(rs1A == 5'd10 && !validA) && n < 200) begin @(posedge clock); #1; n++; end
        readyA = 1'b0;
        n = 0;
        while (!validA && n < 10) begin @(posedge clock); #1; n++; end
        check("abort_idx", 32'(idxA), 32'd10);
        abortA = 1'b1;
        @(posedge clock); #1;
        abortA = 1'b0;
        check("abort_done",  32'(doneA),  32'd1);
        check("abort_wc",    32'(wcA),    32'd10);
        check("abort_valid", 32'(validA), 32'd0);
        @(posedge clock); #1;
        check("abort_busy",  32'(busyA),  32'd0);
        check("abort_done_clr", 32'(doneA), 32'd0);
        readyA = 1'b1;

        // SKIP_ZERO instance: only two nonzero registers are emitted.
        start_and_wait(1, cyc);
        check("skip_cycle", 32'(cyc),         32'd97);
        check("skip_wc",    32'(wcB),         32'd2);
        check("skip_count", 32'(qiB.size()),  32'd2);
        if (qiB.size() == 2) begin
            check("skip_idx0", 32'(qiB[0]), 32'd2);
            check("skip_dat0", qdB[0],      32'd7);
            check("skip_idx1", 32'(qiB[1]), 32'd29);
            check("skip_dat1", qdB[1],      32'd252);
        end
        @(posedge clock); #1;
        check("skip_done_pulses", 32'(doneCntB), 32'd1);

        // Sub-range instance: indices 4..6 only.
        start_and_wait(2, cyc);
        check("range_cycle", 32'(cyc),        32'd10);
        check("range_wc",    32'(wcC),        32'd3);
        check("range_count", 32'(qiC.size()), 32'd3);
        for (int i = 0; i < qiC.size() && i < 3; i++) begin
            check($sformatf("range_idx%0d", i), 32'(qiC[i]), 32'(i + 4));
            check($sformatf("range_dat%0d", i), qdC[i],      32'(i + 104));
        end
        @(posedge clock); #1;
        check("range_max_rs1", 32'(maxRs1C), 32'd6);

        // Reset mid-dump discards it without a done pulse.
        qiA.delete(); qdA.delete();
        dc = doneCntA;
        startA = 1'b1;
        @(posedge clock); #1;
        startA = 1'b0;
        n = 0;
        while (!(validA && idxA == 5'd15) && n < 200) begin @(posedge clock); #1; n++; end
        check("midrst_reached", 32'(idxA), 32'd15);
        reset = 1'b0;
        #1;
        check("midrst_rs1",   32'(rs1A),   32'd0);
        check("midrst_data",  dataA,       32'd0);
        check("midrst_idx",   32'(idxA),   32'd0);
        check("midrst_wc",    32'(wcA),    32'd0);
        check("midrst_valid", 32'(validA), 32'd0);
        check("midrst_busy",  32'(busyA),  32'd0);
        check("midrst_done",  32'(doneA),  32'd0);
        repeat (2) @(posedge clock);
        check("midrst_no_done", 32'(doneCntA - dc), 32'd0);
        #1 reset = 1'b1;
        qiA.delete(); qdA.delete();
        start_and_wait(0, cyc);
        check("after_rst_cycle", 32'(cyc), 32'd97);
        check("after_rst_wc",    32'(wcA), 32'd32);
        check_words_A("after_rst");

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
